// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: control width, operation
// encodings and FSM state encoding.
package alu_pkg;

    localparam int CTRL_W = 3;

    localparam logic [CTRL_W-1:0] ALU_ADD  = 3'b000;
    localparam logic [CTRL_W-1:0] ALU_MUL  = 3'b001;
    localparam logic [CTRL_W-1:0] ALU_SUB  = 3'b010;
    localparam logic [CTRL_W-1:0] ALU_AND  = 3'b011;
    localparam logic [CTRL_W-1:0] ALU_OR   = 3'b100;
    localparam logic [CTRL_W-1:0] ALU_XOR  = 3'b101;
    localparam logic [CTRL_W-1:0] ALU_SLT  = 3'b110;
    localparam logic [CTRL_W-1:0] ALU_RSVD = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier. One partial product per cycle,
// WIDTH iterations after start. product is the accumulator value that the
// current iteration produces, so it is final in the cycle done is high.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   op1,
    input  logic [WIDTH-1:0]   op2,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic               r_busy;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] w_acc_next;

    // Accumulator value after the current iteration's conditional add
    always_comb begin
        w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    end

    assign product = w_acc_next;
    assign done    = r_busy && (r_cnt == '0);

    // Load operands on start, then shift-add once per cycle until the count expires
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (start) begin
            r_busy   <= 1'b1;
            r_cnt    <= CNT_W'(WIDTH - 1);
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, op1};
            r_mplier <= op2;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// Handshaked ALU: single-cycle ops finish in one cycle, MUL runs the
// iterative multiplier. Results are held until the consumer takes them.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = alu_pkg::CTRL_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  op1,
    input  logic [WIDTH-1:0]  op2,
    input  logic [CTRL_W-1:0] aluCtrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic              zero,
    output logic              overflow,
    output logic              err,
    output logic              busy
);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_zero_pend;
    logic               r_overflow;
    logic               r_err;

    logic               w_accept;
    logic               w_is_mul;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_product;
    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_res;
    logic               w_ovf;
    logic               w_err;

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign w_accept  = in_valid && in_ready;
    assign w_is_mul  = (aluCtrl == ALU_MUL);
    assign w_sum     = op1 + op2;
    assign w_diff    = op1 - op2;

    assign result    = r_result;
    assign zero      = r_zero;
    assign overflow  = r_overflow;
    assign err       = r_err;

    alu_mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (w_accept && w_is_mul),
        .op1     (op1),
        .op2     (op2),
        .done    (w_mul_done),
        .product (w_product)
    );

    // Single-cycle datapath and its flags
    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        w_err = 1'b0;
        case (aluCtrl)
            ALU_ADD: begin
                w_res = w_sum;
                w_ovf = (op1[WIDTH-1] == op2[WIDTH-1]) && (w_sum[WIDTH-1] != op1[WIDTH-1]);
            end
            ALU_SUB: begin
                w_res = w_diff;
                w_ovf = (op1[WIDTH-1] != op2[WIDTH-1]) && (w_diff[WIDTH-1] != op1[WIDTH-1]);
            end
            ALU_AND: w_res = op1 & op2;
            ALU_OR:  w_res = op1 | op2;
            ALU_XOR: w_res = op1 ^ op2;
            ALU_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
            ALU_MUL: w_res = '0;
            default: w_err = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = w_is_mul ? ST_MUL : ST_DONE;
            ST_MUL:  if (w_mul_done) w_state_next = ST_DONE;
            ST_DONE: if (out_ready) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Output registers: written only at completion so they stay stable while held
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_zero_pend <= 1'b0;
            r_overflow  <= 1'b0;
            r_err       <= 1'b0;
        end else if (w_accept && !w_is_mul) begin
            r_result   <= w_res;
            r_zero     <= (op1 == op2);
            r_overflow <= w_ovf;
            r_err      <= w_err;
        end else if (w_accept) begin
            // MUL: remember the operand comparison until the product is ready
            r_zero_pend <= (op1 == op2);
        end else if ((r_state == ST_MUL) && w_mul_done) begin
            r_result   <= w_product[WIDTH-1:0];
            r_overflow <= |w_product[2*WIDTH-1:WIDTH];
            r_zero     <= r_zero_pend;
            r_err      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
module tb_multicycle_alu;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] op1 = '0;
    logic [W-1:0] op2 = '0;
    logic [2:0]   aluCtrl = 3'b000;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         zero;
    logic         overflow;
    logic         err;
    logic         busy;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    multicycle_alu #(.WIDTH(W), .CTRL_W(3)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .aluCtrl(aluCtrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .overflow(overflow),
        .err(err), .busy(busy)
    );

    typedef struct {
        string       name;
        logic [2:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic        exp_zero;
        logic        exp_ovf;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Present one op, wait for accept, then count edges until out_valid
    task automatic do_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                         output int k, output bit busy_ok);
        int guard;
        @(negedge clock);
        in_valid = 1'b1; aluCtrl = c; op1 = a; op2 = b;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        k = 0;
        busy_ok = 1'b1;
        while (!out_valid && k < 200) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clock); #1;
            k++;
        end
    endtask

    task automatic release_result(input string name);
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        chk({name, "_released"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int k;
        bit bok;
        logic [31:0] held;

        vecs[0]  = '{"add_ovf",  3'b000, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1'b1, 1'b0, 0};
        vecs[1]  = '{"sub_eq",   3'b010, 32'h1234,     32'h1234,     32'h0,        1'b1, 1'b0, 1'b0, 0};
        vecs[2]  = '{"slt_neg",  3'b110, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1'b0, 1'b0, 0};
        vecs[3]  = '{"mul_7x6",  3'b001, 32'd7,        32'd6,        32'd42,       1'b0, 1'b0, 1'b0, W};
        vecs[4]  = '{"mul_ovf",  3'b001, 32'h10000,    32'h10000,    32'h0,        1'b1, 1'b1, 1'b0, W};
        vecs[5]  = '{"rsvd",     3'b111, 32'd5,        32'd5,        32'h0,        1'b1, 1'b0, 1'b1, 0};
        vecs[6]  = '{"add_2_3",  3'b000, 32'd2,        32'd3,        32'd5,        1'b0, 1'b0, 1'b0, 0};
        vecs[7]  = '{"and",      3'b011, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 1'b0, 0};
        vecs[8]  = '{"or",       3'b100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0, 0};
        vecs[9]  = '{"xor",      3'b101, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0, 1'b0, 1'b0, 0};
        vecs[10] = '{"sub_ovf",  3'b010, 32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 0};
        vecs[11] = '{"mul_ffx2", 3'b001, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, W};
        vecs[12] = '{"slt_pos",  3'b110, 32'h1,        32'hFFFFFFFF, 32'h0,        1'b0, 1'b0, 1'b0, 0};
        vecs[13] = '{"mul_x0",   3'b001, 32'h12345678, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, W};

        // Reset state
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_result",    result,             32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Directed vectors
        for (int i = 0; i < 14; i++) begin
            do_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, k, bok);
            $display("vec %0d %s: ctrl=%0d a=0x%08h b=0x%08h -> res=0x%08h z=%0b o=%0b e=%0b lat=%0d",
                     i, vecs[i].name, vecs[i].ctrl, vecs[i].a, vecs[i].b, result, zero, overflow, err, k);
            chk({vecs[i].name, "_lat"},  k,                   vecs[i].exp_lat);
            chk({vecs[i].name, "_res"},  result,              vecs[i].exp_res);
            chk({vecs[i].name, "_zero"}, {31'd0, zero},       {31'd0, vecs[i].exp_zero});
            chk({vecs[i].name, "_ovf"},  {31'd0, overflow},   {31'd0, vecs[i].exp_ovf});
            chk({vecs[i].name, "_err"},  {31'd0, err},        {31'd0, vecs[i].exp_err});
            if (vecs[i].ctrl == 3'b001) chk({vecs[i].name, "_busy"}, {31'd0, bok}, 32'd1);
            release_result(vecs[i].name);
        end

        // Backpressure: hold result 10 cycles while a new op waits
        do_op(3'b000, 32'd10, 32'd20, k, bok);
        held = result;
        @(negedge clock);
        in_valid = 1'b1; aluCtrl = 3'b010; op1 = 32'd100; op2 = 32'd1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clock); #1;
            chk("bp_result",    result,             32'd30);
            chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        $display("backpressure: held 0x%08h for 10 cycles, now 0x%08h", held, result);
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        chk("bp_idle", {30'd0, in_ready, out_valid}, 32'd2);
        @(posedge clock); #1;
        in_valid = 1'b0;
        chk("bp_next_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_next_res",   result,             32'd99);
        $display("backpressure follow-up: SUB 100-1 -> 0x%08h", result);
        release_result("bp_next");

        // Reset in the middle of a multiply
        @(negedge clock);
        in_valid = 1'b1; aluCtrl = 3'b001; op1 = 32'd3; op2 = 32'd5;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy",      {31'd0, busy},      32'd0);
        chk("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_result",    result,             32'd0);
        $display("mid-mul reset: busy=%0b in_ready=%0b out_valid=%0b", busy, in_ready, out_valid);
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); #1;
            chk("post_rst_idle", {31'd0, out_valid}, 32'd0);
        end

        // Reset while a result is held
        do_op(3'b000, 32'd1, 32'd1, k, bok);
        #2;
        reset_n = 1'b0;
        #1;
        chk("done_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("done_rst_result",    result,             32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
